dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
Arbitrates the four-chip (4 x 8-bit) data SRAM between the single-cycle core backend and a word-burst DMA/bootloader port. Core accesses pass through combinationally when granted, adding no latency. DMA runs registered bursts, and the core is stalled while a burst owns the RAM. Anti-starvation counters bound the wait on each side. Sits between backend memory-access logic and the SRAM array.

Parameters:
ADDR_W, 15, word address width (byte address bits [16:2])
LEN_W, 5, DMA burst length field width (max 31 words)
STARVE_LIMIT, 4, cycles a requester may wait before it is forced one slot (range 1..15)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active HIGH
core_req_n  in  1  core access request, active LOW
core_we_n  in  1  core write, active LOW
core_addr  in  ADDR_W  core word address
core_be_n  in  4  core byte-lane enables, active LOW
core_wdata  in  32  core store data (pre-replicated per lane)
core_rdata  out  32  RAM read data to core, same cycle
core_stall_n  out  1  LOW = core access not performed this cycle; core must hold its request
dma_req_n  in  1  burst request, active LOW; sampled only in IDLE
dma_we_n  in  1  burst direction, LOW = write
dma_addr  in  ADDR_W  burst start word address
dma_len  in  LEN_W  burst word count
dma_wdata  in  32  write word; consumed on each dma_ack_n LOW cycle
dma_rdata  out  32  read word; valid on each dma_ack_n LOW cycle
dma_ack_n  out  1  LOW = one DMA word transferred this cycle
dma_done_n  out  1  LOW for one cycle at burst completion
ram_cs_n  out  1  SRAM chip select, all chips
ram_oe_n  out  1  SRAM output enable
ram_we_n  out  4  per-chip write enable
ram_addr  out  ADDR_W  SRAM address
ram_wdata  out  32  write data, driven only when ram_wdata_oe = 1
ram_wdata_oe  out  1  tri-state enable for the SRAM data pins
ram_rdata  in  32  SRAM data pins, read value
perf_stall_cnt  out  16  core stall-cycle counter (see Optional Feature)

Behaviour:
- Reset (async, rst HIGH): state IDLE, all counters 0. ram_cs_n=1, ram_oe_n=1, ram_we_n=4'hF, ram_wdata_oe=0, core_stall_n=1, dma_ack_n=1, dma_done_n=1, perf_stall_cnt=0. Reset during a burst abandons it silently: no ack, no done.
- SRAM cycle: one word per clk. The SRAM samples on the falling edge; ram_* are combinational from the current grant. A read drives ram_oe_n=0 and ram_we_n=F. A write drives ram_oe_n=1, ram_we_n=be_n (DMA uses 4'h0), and ram_wdata_oe=1.
- FSM states: IDLE, DMA, YIELD.
- IDLE:
  - If core_req_n=0, the core is granted: stall_n=1, and core_rdata=ram_rdata in the same cycle.
  - If dma_req_n=0 and the core is idle, latch dma_addr, dma_len and dma_we_n, then go to DMA.
  - If both request, the core wins. dma_wait increments each losing cycle. When dma_wait reaches STARVE_LIMIT, the core gets stall_n=0 that cycle, the DMA is latched, and the FSM moves to DMA.
- DMA:
  - Each cycle, access the word at addr_cnt and pull dma_ack_n LOW.
  - addr_cnt increments modulo 2^ADDR_W (wraps 7FFF->0000). remain decrements.
  - On the last word (remain=1), dma_done_n is LOW together with that ack, then go to IDLE.
  - Core requests during DMA get stall_n=0, and core_wait increments. When core_wait reaches STARVE_LIMIT, go to YIELD.
- YIELD: the core is granted for exactly one cycle (stall_n=1) and core_wait clears. Return to DMA; remain and addr_cnt are held across YIELD.
- dma_len=0: accepted, no RAM access. dma_done_n is LOW in the cycle after acceptance, then IDLE.
- Changes on dma_req_n, dma_addr and dma_len during a burst are ignored. A new burst requires dma_req_n LOW in IDLE; a held request starts the next burst back-to-back after one IDLE cycle.
- Wait counters clear whenever their requester is granted or deasserts its request.

Optional Feature:
- Macro DMEM_ARB_PERF_EN.
- Defined: perf_stall_cnt increments on every cycle with core_req_n=0 and core_stall_n=0, saturating at FFFF, and is cleared only by rst.
- Undefined: perf_stall_cnt is tied to 16'h0000 and no counter logic exists.

Test Plan:
- Core read only: core_req_n=0, addr 0x0010, memory holds 0xDEADBEEF -> same-cycle core_rdata=0xDEADBEEF, core_stall_n=1, ram_we_n=F.
- DMA write burst: addr 0x7FFE, len 4, data 1..4, core idle -> 4 consecutive acks to addresses 7FFE, 7FFF, 0000, 0001; done_n with the 4th ack; readback matches.
- Contention: core_req_n held LOW and DMA requests, STARVE_LIMIT=4 -> core served 4 cycles, stalled on the 5th, burst starts on the 6th.
- Core during a 10-word DMA read: core_req_n held LOW -> 4 stall cycles, then 1 YIELD grant, then the burst resumes at the next address with no word lost or duplicated.
- dma_len=0 -> no RAM access (ram_cs_n=1), done_n LOW one cycle later; then rst asserted mid-burst at word 2 of 5 -> all outputs go to reset values immediately, no done_n.
- With DMEM_ARB_PERF_EN, the previous contention case -> perf_stall_cnt=1; without the macro -> perf_stall_cnt=0.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the 4 x 8-bit data SRAM between the single-cycle core
// backend and a word-burst DMA/bootloader port.
//   - Core accesses pass straight through to the SRAM when granted (no latency).
//   - DMA bursts run one word per clock from a latched start address/length;
//     the core is stalled while a burst owns the RAM.
//   - Starvation counters bound the wait on both sides: DMA is forced in after
//     STARVE_LIMIT lost IDLE cycles, and the core gets one YIELD slot after
//     STARVE_LIMIT stalled DMA cycles.
// Ports:
//   clk, rst (async, active high)
//   core_*  : core request/data (active-low strobes), core_rdata, core_stall_n
//   dma_*   : burst request/len/addr/data, dma_ack_n per word, dma_done_n at end
//   ram_*   : SRAM control/address/data; ram_wdata_oe enables the data pins
//   perf_stall_cnt : core stall-cycle counter
// Optional feature macro: DMEM_ARB_PERF_EN (enables perf_stall_cnt; otherwise 0).
module dmem_arbiter #(
  parameter int unsigned ADDR_W       = 15,
  parameter int unsigned LEN_W        = 5,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_req_n,
  input  logic              core_we_n,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [3:0]        core_be_n,
  input  logic [31:0]       core_wdata,
  output logic [31:0]       core_rdata,
  output logic              core_stall_n,
  input  logic              dma_req_n,
  input  logic              dma_we_n,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [LEN_W-1:0]  dma_len,
  input  logic [31:0]       dma_wdata,
  output logic [31:0]       dma_rdata,
  output logic              dma_ack_n,
  output logic              dma_done_n,
  output logic              ram_cs_n,
  output logic              ram_oe_n,
  output logic [3:0]        ram_we_n,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  output logic              ram_wdata_oe,
  input  logic [31:0]       ram_rdata,
  output logic [15:0]       perf_stall_cnt
);

  typedef enum logic [1:0] {ST_IDLE, ST_DMA, ST_YIELD} state_e;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LEN_W-1:0]    remain_q, remain_d;
  logic                dir_we_n_q, dir_we_n_d;
  logic [3:0]          dma_wait_q, dma_wait_d;
  logic [3:0]          core_wait_q, core_wait_d;
  logic                core_gnt, dma_gnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      remain_q    <= '0;
      dir_we_n_q  <= 1'b1;
      dma_wait_q  <= '0;
      core_wait_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remain_q    <= remain_d;
      dir_we_n_q  <= dir_we_n_d;
      dma_wait_q  <= dma_wait_d;
      core_wait_q <= core_wait_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    remain_d     = remain_q;
    dir_we_n_d   = dir_we_n_q;
    dma_wait_d   = dma_wait_q;
    core_wait_d  = core_wait_q;
    core_gnt     = 1'b0;
    dma_gnt      = 1'b0;
    core_stall_n = 1'b1;
    dma_ack_n    = 1'b1;
    dma_done_n   = 1'b1;
    unique case (state_q)
      ST_IDLE: begin
        core_wait_d = '0;
        if (dma_req_n) dma_wait_d = '0;
        // Core wins ties unless the DMA has already lost LIMIT cycles.
        if (!core_req_n && !(!dma_req_n && dma_wait_q >= LIMIT)) begin
          core_gnt = 1'b1;
          if (!dma_req_n) dma_wait_d = dma_wait_q + 4'd1;
        end else if (!dma_req_n) begin
          addr_d     = dma_addr;
          remain_d   = dma_len;
          dir_we_n_d = dma_we_n;
          dma_wait_d = '0;
          state_d    = ST_DMA;
          if (!core_req_n) core_stall_n = 1'b0;
        end
      end
      ST_DMA: begin
        if (remain_q == '0) begin
          // Zero-length burst: completes without touching the RAM.
          dma_done_n = 1'b0;
          state_d    = ST_IDLE;
        end else begin
          dma_gnt   = 1'b1;
          dma_ack_n = 1'b0;
          addr_d    = addr_q + ADDR_W'(1);
          remain_d  = remain_q - LEN_W'(1);
          if (remain_q == LEN_W'(1)) begin
            dma_done_n = 1'b0;
            state_d    = ST_IDLE;
          end
        end
        if (!core_req_n) begin
          core_stall_n = 1'b0;
          core_wait_d  = core_wait_q + 4'd1;
          // Completion takes precedence; IDLE serves the core next cycle anyway.
          if (core_wait_q >= LIMIT - 4'd1 && state_d == ST_DMA) state_d = ST_YIELD;
        end else begin
          core_wait_d = '0;
        end
      end
      ST_YIELD: begin
        core_wait_d = '0;
        state_d     = ST_DMA;
        if (!core_req_n) core_gnt = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ram_cs_n     = 1'b1;
    ram_oe_n     = 1'b1;
    ram_we_n     = '1;
    ram_addr     = '0;
    ram_wdata    = '0;
    ram_wdata_oe = 1'b0;
    if (core_gnt) begin
      ram_cs_n = 1'b0;
      ram_addr = core_addr;
      if (!core_we_n) begin
        ram_we_n     = core_be_n;
        ram_wdata    = core_wdata;
        ram_wdata_oe = 1'b1;
      end else begin
        ram_oe_n = 1'b0;
      end
    end else if (dma_gnt) begin
      ram_cs_n = 1'b0;
      ram_addr = addr_q;
      if (!dir_we_n_q) begin
        ram_we_n     = '0;
        ram_wdata    = dma_wdata;
        ram_wdata_oe = 1'b1;
      end else begin
        ram_oe_n = 1'b0;
      end
    end
  end

  assign core_rdata = ram_rdata;
  assign dma_rdata  = ram_rdata;

`ifdef DMEM_ARB_PERF_EN
  logic [15:0] perf_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_q <= '0;
    end else if (!core_req_n && !core_stall_n && perf_q != '1) begin
      perf_q <= perf_q + 16'd1;
    end
  end

  assign perf_stall_cnt = perf_q;
`else
  assign perf_stall_cnt = '0;
`endif

endmodule
